// File: rtl/ika3012_pkg.sv
// Shared constants and state encoding for the IKA3012 serial sample receiver.
package ika3012_pkg;

   localparam int SO_BITS = 16;
   localparam int MANT_W  = 10;
   localparam int EXP_W   = 3;
   localparam int WORD_W  = MANT_W + EXP_W;

   // Strobe-to-strobe spacing is 16 ticks, so the counter reads 15 at a good edge.
   localparam logic [4:0] FRAME_CNT = 5'd15;
   localparam logic [4:0] CNT_MAX   = 5'd31;

   typedef enum logic {
      ST_UNSYNC = 1'b0,
      ST_SYNC   = 1'b1
   } rx_state_t;

endpackage

// File: rtl/ika3012_fp2lin.sv
// Floating-point DAC word (3-bit exponent, 10-bit offset-binary mantissa) to
// 16-bit signed linear sample.
import ika3012_pkg::*;

module ika3012_fp2lin (
   input  logic [WORD_W-1:0] word,
   output logic [15:0]       sample
);

   logic [MANT_W-1:0] mant;
   logic [EXP_W-1:0]  expo;
   logic [15:0]       s_ext;

   assign mant = word[MANT_W-1:0];
   assign expo = word[WORD_W-1:MANT_W];

   // Offset binary -> two's complement is just the MSB flipped; the flipped
   // MSB is also the sign used for extension.
   assign s_ext = {{(16-MANT_W){~mant[MANT_W-1]}}, ~mant[MANT_W-1], mant[MANT_W-2:0]};

   always_comb begin
      sample = '0;
      if (expo != '0)
         sample = s_ext << (expo - 3'd1);
   end

endmodule

// File: rtl/ika3012_sample_rx.sv
// Deserialises the IKA3012 sample stream framed by SH1/SH2 into left/right
// linear samples, tracking frame lock.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_UNSYNC | waiting for an SH1 falling edge to establish frame phase
//   ST_SYNC   | locked; alternate SH2 (right) / SH1 (left) edges 16 ticks apart
import ika3012_pkg::*;

module ika3012_sample_rx (
   input  logic        i_EMUCLK,
   input  logic        i_RST,
   input  logic        i_PHI1_NCEN_n,
   input  logic        i_SO,
   input  logic        i_SH1,
   input  logic        i_SH2,
   output logic [15:0] o_SAMPLE_L,
   output logic [15:0] o_SAMPLE_R,
   output logic        o_L_STB,
   output logic        o_R_STB,
   output logic        o_SYNC_ERR,
   output logic        o_LOCKED
);

   logic               tick;
   logic [SO_BITS-1:0] sr;
   logic               sh1_q;
   logic               sh2_q;
   logic [4:0]         cnt;
   rx_state_t          state;
   logic               expect_sh2;

   logic               pend_vld;
   logic               pend_is_r;
   logic [WORD_W-1:0]  pend_word;
   logic [15:0]        pend_lin;

   logic               fall1;
   logic               fall2;
   logic               exp_hit;
   logic               frame_ok;

   assign tick     = ~i_PHI1_NCEN_n;
   assign fall1    = sh1_q & ~i_SH1;
   assign fall2    = sh2_q & ~i_SH2;
   assign exp_hit  = expect_sh2 ? (fall2 & ~fall1) : (fall1 & ~fall2);
   assign frame_ok = exp_hit && (cnt == FRAME_CNT);

   ika3012_fp2lin u_fp2lin (
      .word   (pend_word),
      .sample (pend_lin)
   );

   always_ff @(posedge i_EMUCLK) begin
      if (i_RST) begin
         sr    <= '0;
         sh1_q <= 1'b0;
         sh2_q <= 1'b0;
         cnt   <= '0;
      end else if (tick) begin
         sr    <= {i_SO, sr[SO_BITS-1:1]};
         sh1_q <= i_SH1;
         sh2_q <= i_SH2;
         if (fall1 || fall2)
            cnt <= '0;
         else if (cnt != CNT_MAX)
            cnt <= cnt + 5'd1;
      end
   end

   // The word is captured from sr before this tick's shift; conversion and
   // output happen on the next tick, so a new edge may load pend_* in the
   // same cycle the previous word is being emitted.
   always_ff @(posedge i_EMUCLK) begin
      if (i_RST) begin
         state      <= ST_UNSYNC;
         expect_sh2 <= 1'b0;
         pend_vld   <= 1'b0;
         pend_is_r  <= 1'b0;
         pend_word  <= '0;
         o_SAMPLE_L <= '0;
         o_SAMPLE_R <= '0;
         o_L_STB    <= 1'b0;
         o_R_STB    <= 1'b0;
         o_SYNC_ERR <= 1'b0;
         o_LOCKED   <= 1'b0;
      end else begin
         o_L_STB    <= 1'b0;
         o_R_STB    <= 1'b0;
         o_SYNC_ERR <= 1'b0;
         if (tick) begin
            if (pend_vld) begin
               pend_vld <= 1'b0;
               if (pend_is_r) begin
                  o_SAMPLE_R <= pend_lin;
                  o_R_STB    <= 1'b1;
               end else begin
                  o_SAMPLE_L <= pend_lin;
                  o_L_STB    <= 1'b1;
               end
            end
            case (state)
               ST_UNSYNC: begin
                  if (fall1 && !fall2) begin
                     state      <= ST_SYNC;
                     expect_sh2 <= 1'b1;
                     o_LOCKED   <= 1'b1;
                  end
               end
               ST_SYNC: begin
                  if (fall1 || fall2) begin
                     if (frame_ok) begin
                        pend_vld   <= 1'b1;
                        pend_is_r  <= expect_sh2;
                        pend_word  <= sr[SO_BITS-1 -: WORD_W];
                        expect_sh2 <= ~expect_sh2;
                     end else begin
                        o_SYNC_ERR <= 1'b1;
                        if (fall1 && !fall2) begin
                           expect_sh2 <= 1'b1;
                        end else begin
                           state    <= ST_UNSYNC;
                           o_LOCKED <= 1'b0;
                        end
                     end
                  end
               end
               default: begin
                  state    <= ST_UNSYNC;
                  o_LOCKED <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ika3012_sample_rx.sv
// Directed bench for ika3012_sample_rx with a strobe scoreboard.
module tb_ika3012_sample_rx;

   localparam logic [15:0] K_L   = 16'd1;
   localparam logic [15:0] K_R   = 16'd2;
   localparam logic [15:0] K_ERR = 16'd3;

   typedef struct {
      logic [15:0] kind;
      logic [15:0] val;
   } ev_t;

   logic        i_EMUCLK = 1'b0;
   logic        i_RST = 1'b1;
   logic        i_PHI1_NCEN_n = 1'b1;
   logic        i_SO = 1'b0;
   logic        i_SH1 = 1'b0;
   logic        i_SH2 = 1'b0;
   logic [15:0] o_SAMPLE_L;
   logic [15:0] o_SAMPLE_R;
   logic        o_L_STB;
   logic        o_R_STB;
   logic        o_SYNC_ERR;
   logic        o_LOCKED;

   int          checks = 0;
   int          errors = 0;
   ev_t         sb[$];
   logic [15:0] exp_l = '0;
   logic [15:0] exp_r = '0;

   logic [12:0] l_words [4] = '{13'h1FFF, 13'h1C00, 13'h0600, 13'h0155};
   logic [15:0] l_const [4] = '{16'h7FC0, 16'h8000, 16'h0000, 16'h0000};
   logic [12:0] r_words [5] = '{13'h0A5A, 13'h1234, 13'h0C01, 13'h07FF, 13'h1B3C};

   ika3012_sample_rx dut (
      .i_EMUCLK      (i_EMUCLK),
      .i_RST         (i_RST),
      .i_PHI1_NCEN_n (i_PHI1_NCEN_n),
      .i_SO          (i_SO),
      .i_SH1         (i_SH1),
      .i_SH2         (i_SH2),
      .o_SAMPLE_L    (o_SAMPLE_L),
      .o_SAMPLE_R    (o_SAMPLE_R),
      .o_L_STB       (o_L_STB),
      .o_R_STB       (o_R_STB),
      .o_SYNC_ERR    (o_SYNC_ERR),
      .o_LOCKED      (o_LOCKED)
   );

   always #5 i_EMUCLK = ~i_EMUCLK;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference conversion: offset-binary mantissa minus 512, scaled by 2^(E-1).
   function automatic logic [15:0] model(input logic [12:0] w);
      int m, e, v;
      m = int'(w[9:0]);
      e = int'(w[12:10]);
      v = (e == 0) ? 0 : (m - 512) * (1 << (e - 1));
      return v[15:0];
   endfunction

   task automatic push(input logic [15:0] kind, input logic [15:0] val);
      ev_t e;
      e.kind = kind;
      e.val  = val;
      sb.push_back(e);
      if (kind == K_L) exp_l = val;
      if (kind == K_R) exp_r = val;
   endtask

   task automatic take(input logic [15:0] kind, input logic [15:0] val);
      ev_t e;
      checks++;
      assert (sb.size() != 0)
      else begin
         errors++;
         $error("FAIL unexpected_strobe: observed kind %0d, expected no strobe", kind);
      end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk("strobe_kind", kind, e.kind);
         chk("strobe_value", val, e.val);
      end
   endtask

   always @(negedge i_EMUCLK) begin
      if (o_L_STB)    take(K_L, o_SAMPLE_L);
      if (o_R_STB)    take(K_R, o_SAMPLE_R);
      if (o_SYNC_ERR) take(K_ERR, 16'h0000);
   end

   // One phi1 period: a tick cycle followed by an idle cycle.
   task automatic do_tick(input logic so, input logic sh1, input logic sh2);
      @(negedge i_EMUCLK);
      i_SO = so; i_SH1 = sh1; i_SH2 = sh2; i_PHI1_NCEN_n = 1'b0;
      @(posedge i_EMUCLK);
      @(negedge i_EMUCLK);
      i_PHI1_NCEN_n = 1'b1;
      @(posedge i_EMUCLK);
   endtask

   // Falling edges land on tick 0 of the frame after one with hi1/hi2 set.
   task automatic frame(input logic [12:0] w, input bit hi1, input bit hi2,
                        input int len, input int gap_at);
      logic [15:0] d;
      d = {w, 3'b101};
      for (int j = 0; j < len; j++) begin
         if (j == gap_at) begin
            #1;
            chk("gap_locked_before", {15'd0, o_LOCKED}, 16'h0001);
            repeat (100) @(posedge i_EMUCLK);
            #1;
            chk("gap_locked_after", {15'd0, o_LOCKED}, 16'h0001);
            chk("gap_sample_r", o_SAMPLE_R, exp_r);
            chk("gap_sample_l", o_SAMPLE_L, exp_l);
         end
         do_tick((j < 16) ? d[j] : 1'b0, hi1 && (j >= len - 8), hi2 && (j >= len - 8));
      end
   endtask

   initial begin
      // Reset with enable active: reset must win.
      i_PHI1_NCEN_n = 1'b0;
      i_SH1 = 1'b1;
      repeat (4) @(posedge i_EMUCLK);
      @(negedge i_EMUCLK);
      i_RST = 1'b0; i_SH1 = 1'b0; i_PHI1_NCEN_n = 1'b1;
      #1;
      chk("rst_sample_l", o_SAMPLE_L, 16'h0000);
      chk("rst_sample_r", o_SAMPLE_R, 16'h0000);
      chk("rst_locked", {15'd0, o_LOCKED}, 16'h0000);
      chk("rst_strobes", {13'd0, o_L_STB, o_R_STB, o_SYNC_ERR}, 16'h0000);

      // Lock and stream conversion patterns.
      frame(13'h0000, 1, 0, 16, -1);
      chk("pre_lock", {15'd0, o_LOCKED}, 16'h0000);
      frame(r_words[0], 0, 1, 16, -1);
      #1 chk("lock", {15'd0, o_LOCKED}, 16'h0001);
      for (int i = 0; i < 4; i++) begin
         push(K_R, model(r_words[i]));
         frame(l_words[i], 1, 0, 16, -1);
         push(K_L, model(l_words[i]));
         frame(r_words[i + 1], 0, 1, 16, -1);
         #1 chk("sample_l_const", o_SAMPLE_L, l_const[i]);
         chk("sample_r_model", o_SAMPLE_R, model(r_words[i]));
      end

      // Early SH2 edge, 12 ticks after SH1.
      push(K_R, model(r_words[4]));
      frame(13'h0AAA, 1, 0, 16, -1);
      push(K_L, model(13'h0AAA));
      frame(13'h1555, 0, 1, 12, -1);
      push(K_ERR, 16'h0000);
      frame(13'h0333, 1, 0, 16, -1);
      #1 chk("early_unlocked", {15'd0, o_LOCKED}, 16'h0000);
      chk("early_sample_r", o_SAMPLE_R, exp_r);
      frame(13'h1E0F, 0, 1, 16, -1);
      #1 chk("relock", {15'd0, o_LOCKED}, 16'h0001);
      push(K_R, model(13'h1E0F));
      frame(13'h1A5A, 1, 0, 16, -1);

      // Simultaneous SH1/SH2 edges.
      push(K_L, model(13'h1A5A));
      frame(13'h0F0F, 1, 1, 16, -1);
      push(K_ERR, 16'h0000);
      frame(13'h1111, 0, 0, 16, -1);
      #1 chk("simul_unlocked", {15'd0, o_LOCKED}, 16'h0000);
      chk("simul_sample_l", o_SAMPLE_L, exp_l);
      chk("simul_sample_r", o_SAMPLE_R, exp_r);

      // Reset 8 ticks after a locking SH1 edge.
      frame(13'h0000, 1, 0, 16, -1);
      frame(13'h1FFF, 0, 0, 8, -1);
      #1 chk("mid_locked", {15'd0, o_LOCKED}, 16'h0001);
      @(negedge i_EMUCLK);
      i_RST = 1'b1; i_PHI1_NCEN_n = 1'b0;
      repeat (3) @(posedge i_EMUCLK);
      @(negedge i_EMUCLK);
      i_RST = 1'b0; i_PHI1_NCEN_n = 1'b1;
      exp_l = '0;
      exp_r = '0;
      #1;
      chk("mid_rst_sample_l", o_SAMPLE_L, 16'h0000);
      chk("mid_rst_sample_r", o_SAMPLE_R, 16'h0000);
      chk("mid_rst_locked", {15'd0, o_LOCKED}, 16'h0000);
      frame(13'h0000, 1, 0, 16, -1);
      frame(13'h1C7F, 0, 1, 16, -1);
      #1 chk("relock_no_out_l", o_SAMPLE_L, 16'h0000);
      chk("relock_no_out_r", o_SAMPLE_R, 16'h0000);

      // Enable held off for 100 cycles mid-frame.
      push(K_R, model(13'h1C7F));
      frame(13'h0BCD, 1, 0, 16, 8);
      push(K_L, model(13'h0BCD));
      frame(13'h0000, 0, 0, 4, -1);
      #1 chk("final_sample_l", o_SAMPLE_L, model(13'h0BCD));
      chk("final_sample_r", o_SAMPLE_R, model(13'h1C7F));
      chk("scoreboard_drained", sb.size() > 0 ? 16'h0001 : 16'h0000, 16'h0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ika3012_sample_rx.md
IKA3012_SAMPLE_RX -- requirements
Module: ika3012_sample_rx

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high.
REQ-002 SHALL have these ports:
  - i_EMUCLK  in  1  emulator master clock; all state on rising edge
  - i_RST  in  1  synchronous active-high reset
  - i_PHI1_NCEN_n  in  1  active-low bit-tick enable, one i_EMUCLK cycle per phi1 period
  - i_SO  in  1  serial sample data, LSB first
  - i_SH1  in  1  channel-1 (left) frame strobe
  - i_SH2  in  1  channel-2 (right) frame strobe
  - o_SAMPLE_L  out  16  signed linear left sample
  - o_SAMPLE_R  out  16  signed linear right sample
  - o_L_STB  out  1  one-EMUCLK pulse when o_SAMPLE_L updates
  - o_R_STB  out  1  one-EMUCLK pulse when o_SAMPLE_R updates (frame complete)
  - o_SYNC_ERR  out  1  one-EMUCLK pulse on framing violation
  - o_LOCKED  out  1  high while state is SYNC

Function
REQ-003 SHALL act only on tick cycles (i_PHI1_NCEN_n=0); all other cycles hold state, and strobes are 0.
REQ-004 SHALL, on each tick, shift i_SO into bit 15 of a 16-bit right-shifting register (sr).
REQ-005 SHALL register i_SH1 and i_SH2 on each tick; a falling edge is previous=1 and current=0.
REQ-006 SHALL keep a 5-bit tick counter, cleared on any SH falling edge and saturating at 31.
REQ-007 SHALL implement the FSM UNSYNC -> SYNC as follows:
  - Transition on the first SH1 falling edge, which produces no output.
  - SYNC -> UNSYNC on any framing violation.
REQ-008 SHALL define the expected next edge in SYNC: after SH1 expect SH2, after SH2 expect SH1.
REQ-009 SHALL treat these as framing violations: an edge on the unexpected strobe, counter != 15 at the edge, or SH1 and SH2 falling on the same tick.
  - On a violation: discard the word, pulse o_SYNC_ERR on that tick, and go to UNSYNC.
  - If the violating edge is an SH1 edge (not simultaneous), SHALL go directly to SYNC (resync).
REQ-010 SHALL, on a valid edge, capture the 13-bit word W = sr[15:3] as it stands before that tick's shift.
  - Mantissa M = W[9:0]; exponent E = W[12:10].
REQ-011 SHALL convert the word as follows:
  - Signed mantissa S = M with bit 9 inverted, interpreted as two's complement.
  - E=0 gives 0; E=1..7 gives S sign-extended to 16 bits and shifted left by (E-1).
  - No saturation is needed: range is -32768..+32704.
REQ-012 SHALL update o_SAMPLE_L/o_SAMPLE_R on the tick following the valid edge and pulse o_L_STB/o_R_STB on that same cycle (latency: 1 tick).
REQ-013 SHALL let an edge that coincides with a pending output tick proceed; the pipeline depth is 1 and both operations complete.

Reset
REQ-014 SHALL, on i_RST=1, reset the following; reset overrides enable:
  - state=UNSYNC, sr=0, counter=0, registered SH values=0
  - o_SAMPLE_L=o_SAMPLE_R=0, all strobes=0, o_LOCKED=0
REQ-015 SHALL drop a word in flight when reset is asserted mid-frame, with no strobe after release.
REQ-016 SHALL require, after reset release, one SH1 edge to lock before any output.

Structure
REQ-017 SHALL place these items in package ika3012_pkg:
  - Constants SO_BITS=16, MANT_W=10, EXP_W=3.
  - The FSM state typedef.
REQ-018 SHALL implement the float-to-linear conversion as the combinational sub-module ika3012_fp2lin (13-bit in, 16-bit signed out).

Verification
REQ-019 SHALL cover locking: drive a nominal frame (SH1/SH2 each high 8 ticks, falling edges 16 ticks apart).
  - Required: first SH1 edge gives no strobe and o_LOCKED=1.
  - Required: the following SH2 edge yields o_R_STB.
REQ-020 SHALL cover conversion values:
  - W: E=7, M=0x3FF -> o_SAMPLE_L=+32704 (0x7FC0).
  - W: E=7, M=0x000 -> -32768 (0x8000).
  - W: E=1, M=0x200 -> 0.
  - W: E=0, any M -> 0.
REQ-021 SHALL cover an early edge: SH2 edge arrives 12 ticks after SH1.
  - Required: o_SYNC_ERR pulse, no o_R_STB, o_LOCKED=0.
  - Required: the next SH1 edge relocks.
REQ-022 SHALL cover simultaneous edges: SH1 and SH2 fall on the same tick.
  - Required: o_SYNC_ERR, UNSYNC, and both samples unchanged.
REQ-023 SHALL cover reset mid-frame: assert i_RST 8 ticks after a valid SH1 edge.
  - Required: outputs 0 and no strobes until relock + 16 ticks.
REQ-024 SHALL cover enable gating: hold i_PHI1_NCEN_n=1 for 100 cycles mid-frame.
  - Required: no state change and no strobes.
